// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: sequences the LC-3 MAR/MDR datapath and its RAM for one
// read or write access at a time, handshaking with the main control FSM
// over req/ack.
//
// Optional build macro LC3_MEM_RDY_EN: adds a mem_rdy input from the RAM
// and a timeout output. The wait states then end early on mem_rdy, and
// READ_LAT/WRITE_LAT become timeout limits instead of fixed wait counts.
//
// Every output is a register loaded with the decode of the next state, so
// each output always equals a decode of the current state register. This
// leaves no combinational path from req, we or mem_rdy to any output.
module lc3_mem_ctrl #(
    parameter int READ_LAT  = 2,
    parameter int WRITE_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic we,
`ifdef LC3_MEM_RDY_EN
    input  logic mem_rdy,
    output logic timeout,
`endif
    output logic ack,
    output logic busy,
    output logic LD_MAR,
    output logic LD_MDR,
    output logic mem_en,
    output logic mem_we
);

    // Reject wait-state counts that the 4-bit counter cannot represent.
    generate
        if (READ_LAT < 1 || READ_LAT > 15) begin : g_bad_read_lat
            $error("lc3_mem_ctrl: READ_LAT must be in 1..15");
        end
        if (WRITE_LAT < 1 || WRITE_LAT > 15) begin : g_bad_write_lat
            $error("lc3_mem_ctrl: WRITE_LAT must be in 1..15");
        end
    endgenerate

    // The counter is loaded with LAT-1 so that a wait state lasts LAT cycles.
    localparam logic [3:0] RD_LOAD = 4'(READ_LAT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_RWAIT = 3'd2,
        S_RCAP  = 3'd3,
        S_WDATA = 3'd4,
        S_WWAIT = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_s;
    logic       we_r;
    logic       we_s;
    logic       ack_r;
    logic       busy_r;
    logic       ld_mar_r;
    logic       ld_mdr_r;
    logic       mem_en_r;
    logic       mem_we_r;
`ifdef LC3_MEM_RDY_EN
    logic       to_r;
    logic       to_s;
    logic       timeout_r;
`endif

    // Next-state, wait counter and latched-direction logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        we_s    = we_r;
`ifdef LC3_MEM_RDY_EN
        to_s    = to_r;
`endif
        case (state_r)
            S_IDLE: begin
                if (req) begin
                    state_s = S_ADDR;
                    we_s    = we;
`ifdef LC3_MEM_RDY_EN
                    to_s    = 1'b0;
`endif
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ADDR: begin
                if (we_r) begin
                    state_s = S_WDATA;
                    cnt_s   = WR_LOAD;
                end else begin
                    state_s = S_RWAIT;
                    cnt_s   = RD_LOAD;
                end
            end
            S_RWAIT: begin
`ifdef LC3_MEM_RDY_EN
                if (mem_rdy) begin
                    state_s = S_RCAP;
                end else if (cnt_r == 4'd0) begin
                    state_s = S_RCAP;
                    to_s    = 1'b1;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
`else
                if (cnt_r == 4'd0) begin
                    state_s = S_RCAP;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
`endif
            end
            S_RCAP: begin
                state_s = S_DONE;
            end
            S_WDATA: begin
                state_s = S_WWAIT;
            end
            S_WWAIT: begin
`ifdef LC3_MEM_RDY_EN
                if (mem_rdy) begin
                    state_s = S_DONE;
                end else if (cnt_r == 4'd0) begin
                    state_s = S_DONE;
                    to_s    = 1'b1;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
`else
                if (cnt_r == 4'd0) begin
                    state_s = S_DONE;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
`endif
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = 4'd0;
                we_s    = 1'b0;
            end
        endcase
    end

    // State, counter and output registers; outputs are the next-state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            cnt_r     <= 4'd0;
            we_r      <= 1'b0;
            ack_r     <= 1'b0;
            busy_r    <= 1'b0;
            ld_mar_r  <= 1'b0;
            ld_mdr_r  <= 1'b0;
            mem_en_r  <= 1'b0;
            mem_we_r  <= 1'b0;
`ifdef LC3_MEM_RDY_EN
            to_r      <= 1'b0;
            timeout_r <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            we_r      <= we_s;
            ack_r     <= (state_s == S_DONE);
            busy_r    <= (state_s != S_IDLE);
            ld_mar_r  <= (state_s == S_ADDR);
            ld_mdr_r  <= (state_s == S_RCAP) || (state_s == S_WDATA);
            mem_en_r  <= (state_s == S_RWAIT) || (state_s == S_RCAP);
            mem_we_r  <= (state_s == S_WWAIT);
`ifdef LC3_MEM_RDY_EN
            to_r      <= to_s;
            timeout_r <= (state_s == S_DONE) && to_s;
`endif
        end
    end

    assign ack    = ack_r;
    assign busy   = busy_r;
    assign LD_MAR = ld_mar_r;
    assign LD_MDR = ld_mdr_r;
    assign mem_en = mem_en_r;
    assign mem_we = mem_we_r;
`ifdef LC3_MEM_RDY_EN
    assign timeout = timeout_r;
`endif

endmodule
